// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline register status in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    logic [4:0]             D_ra;
    logic [4:0]             D_rb;
    logic [4:0]             E_ra;
    logic [4:0]             E_rb;
    logic [4:0]             E_rd;
    logic [1:0]             E_result_src;
    logic                   E_RegWrite;
    logic                   E_is_div;
    logic                   E_redirect;
    logic [4:0]             M_rd;
    logic [4:0]             W_rd;
    logic                   M_RegWrite;
    logic                   W_RegWrite;
    logic                   div_done;
    logic                   F_en;
    logic                   F_D_en;
    logic                   F_D_flush;
    logic                   D_E_en;
    logic                   no_op;
    logic                   CTRL_Flush;
    logic                   M_bubble;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;
    logic                   div_start;
    logic                   div_busy;
    logic                   div_timeout;
    logic [STALL_CNT_W-1:0] stall_cycles;

    // Pipeline / divider side driving the controller.
    modport master (
        output D_ra, D_rb, E_ra, E_rb, E_rd, E_result_src, E_RegWrite, E_is_div,
               E_redirect, M_rd, W_rd, M_RegWrite, W_RegWrite, div_done,
        input  F_en, F_D_en, F_D_flush, D_E_en, no_op, CTRL_Flush, M_bubble,
               fwd_a, fwd_b, div_start, div_busy, div_timeout, stall_cycles
    );

    // Controller side.
    modport slave (
        input  D_ra, D_rb, E_ra, E_rb, E_rd, E_result_src, E_RegWrite, E_is_div,
               E_redirect, M_rd, W_rd, M_RegWrite, W_RegWrite, div_done,
        output F_en, F_D_en, F_D_flush, D_E_en, no_op, CTRL_Flush, M_bubble,
               fwd_a, fwd_b, div_start, div_busy, div_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: div stall, redirect flush, load-use stall,
// M/W forwarding selects and the divider start/done/timeout sequencer.
module pipeline_hazard_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam int TW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(DIV_TIMEOUT - 1);

    div_state_t             state, state_nx;
    logic [TW-1:0]          to_cnt;
    logic                   to_flag;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   timeout_hit;
    logic                   div_stall;
    logic                   load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))
            return 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign timeout_hit = (to_cnt == TO_LAST);
    assign div_stall   = ((state == IDLE) && bus.E_is_div) || (state == BUSY);
    assign load_use    = (bus.E_result_src == 2'b01) && bus.E_RegWrite &&
                         (bus.E_rd != 5'd0) &&
                         ((bus.E_rd == bus.D_ra) || (bus.E_rd == bus.D_rb));

    // Divider FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Divider next state and launch pulse.
    always_comb begin
        state_nx      = state;
        bus.div_start = 1'b0;
        unique case (state)
            IDLE: if (bus.E_is_div) begin
                state_nx      = BUSY;
                bus.div_start = !rst;
            end
            BUSY: if (bus.div_done || timeout_hit) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Timeout counter and sticky error; done arriving on the last cycle is not a timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.E_is_div) to_cnt <= '0;
            else if (state == BUSY)              to_cnt <= to_cnt + 1'b1;
            if ((state == BUSY) && !bus.div_done && timeout_hit) to_flag <= 1'b1;
        end
    end

    // Stall/flush controls in priority order: div stall, redirect, load-use, normal.
    always_comb begin
        bus.F_en       = 1'b1;
        bus.F_D_en     = 1'b1;
        bus.D_E_en     = 1'b1;
        bus.F_D_flush  = 1'b0;
        bus.no_op      = 1'b0;
        bus.CTRL_Flush = 1'b0;
        bus.M_bubble   = 1'b0;
        if (rst) begin
            bus.F_en   = 1'b0;
            bus.F_D_en = 1'b0;
            bus.D_E_en = 1'b0;
        end else if (div_stall) begin
            bus.F_en     = 1'b0;
            bus.F_D_en   = 1'b0;
            bus.D_E_en   = 1'b0;
            bus.M_bubble = 1'b1;
        end else if (state == IDLE && bus.E_redirect) begin
            bus.CTRL_Flush = 1'b1;
            bus.F_D_flush  = 1'b1;
        end else if (state == IDLE && load_use) begin
            bus.F_en   = 1'b0;
            bus.F_D_en = 1'b0;
            bus.no_op  = 1'b1;
        end
    end

    // Operand forwarding selects, M result preferred over W.
    always_comb begin
        bus.fwd_a = 2'b00;
        bus.fwd_b = 2'b00;
        if (!rst) begin
            bus.fwd_a = fwd_sel(bus.E_ra, bus.M_rd, bus.M_RegWrite, bus.W_rd, bus.W_RegWrite);
            bus.fwd_b = fwd_sel(bus.E_rb, bus.M_rd, bus.M_RegWrite, bus.W_rd, bus.W_RegWrite);
        end
    end

    // Saturating count of cycles with the PC frozen.
    always_ff @(posedge clk) begin
        if (rst)                           stall_q <= '0;
        else if (!bus.F_en && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    assign bus.div_busy     = (state == BUSY);
    assign bus.div_timeout  = to_flag;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (long and short divide timeout)
// share stimulus and are checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int SW = 8;
    localparam int SMAX = (1 << SW) - 1;
    localparam int TO0 = 16;
    localparam int TO1 = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] d_ra, d_rb, e_ra, e_rb, e_rd, m_rd, w_rd;
    logic [1:0] e_src;
    logic e_we, e_div, e_redir, m_we, w_we, done;

    int n_chk = 0;
    int n_fail = 0;

    pipeline_hazard_ctrl_if #(.STALL_CNT_W(SW)) bus0 ();
    pipeline_hazard_ctrl_if #(.STALL_CNT_W(SW)) bus1 ();

    assign bus0.D_ra = d_ra;          assign bus1.D_ra = d_ra;
    assign bus0.D_rb = d_rb;          assign bus1.D_rb = d_rb;
    assign bus0.E_ra = e_ra;          assign bus1.E_ra = e_ra;
    assign bus0.E_rb = e_rb;          assign bus1.E_rb = e_rb;
    assign bus0.E_rd = e_rd;          assign bus1.E_rd = e_rd;
    assign bus0.E_result_src = e_src; assign bus1.E_result_src = e_src;
    assign bus0.E_RegWrite = e_we;    assign bus1.E_RegWrite = e_we;
    assign bus0.E_is_div = e_div;     assign bus1.E_is_div = e_div;
    assign bus0.E_redirect = e_redir; assign bus1.E_redirect = e_redir;
    assign bus0.M_rd = m_rd;          assign bus1.M_rd = m_rd;
    assign bus0.W_rd = w_rd;          assign bus1.W_rd = w_rd;
    assign bus0.M_RegWrite = m_we;    assign bus1.M_RegWrite = m_we;
    assign bus0.W_RegWrite = w_we;    assign bus1.W_RegWrite = w_we;
    assign bus0.div_done = done;      assign bus1.div_done = done;

    pipeline_hazard_ctrl #(.DIV_TIMEOUT(TO0), .STALL_CNT_W(SW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipeline_hazard_ctrl #(.DIV_TIMEOUT(TO1), .STALL_CNT_W(SW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Behavioural model: a divide is "in flight" for a number of completed busy cycles.
    bit mbusy [2];
    bit mdone [2];
    bit mto   [2];
    int mcnt  [2];
    int mstall[2];
    int tlim  [2] = '{TO0, TO1};

    function automatic int fwdm(input logic [4:0] rs);
        if (m_we && m_rd != 0 && m_rd == rs) return 2;
        if (w_we && w_rd != 0 && w_rd == rs) return 1;
        return 0;
    endfunction

    // Packed order: F_en F_D_en F_D_flush D_E_en no_op CTRL_Flush M_bubble fwd_a fwd_b div_start div_busy div_timeout
    function automatic logic [13:0] model_out(input bit busy, input bit dn, input bit to);
        logic fen, fden, fdfl, deen, nop, cfl, mb, ds;
        logic [1:0] fa, fb;
        bit idle, lu;
        idle = !busy && !dn;
        lu = (e_src == 2'b01) && e_we && (e_rd != 0) && (e_rd == d_ra || e_rd == d_rb);
        fen = 1; fden = 1; deen = 1; fdfl = 0; nop = 0; cfl = 0; mb = 0;
        fa = 2'(fwdm(e_ra)); fb = 2'(fwdm(e_rb));
        ds = idle && e_div;
        if (busy || (idle && e_div)) begin
            fen = 0; fden = 0; deen = 0; mb = 1;
        end else if (idle && e_redir) begin
            cfl = 1; fdfl = 1;
        end else if (idle && lu) begin
            fen = 0; fden = 0; nop = 1;
        end
        if (rst) begin
            fen = 0; fden = 0; deen = 0; fdfl = 0; nop = 0; cfl = 0; mb = 0;
            fa = 0; fb = 0; ds = 0;
        end
        return {fen, fden, fdfl, deen, nop, cfl, mb, fa, fb, ds, logic'(busy), logic'(to)};
    endfunction

    // Model advance at each active edge, from the inputs held across that edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [13:0] o;
            o = model_out(mbusy[k], mdone[k], mto[k]);
            if (rst) begin
                mbusy[k] = 0; mdone[k] = 0; mto[k] = 0; mstall[k] = 0; mcnt[k] = 0;
            end else begin
                if (!o[13] && mstall[k] < SMAX) mstall[k] = mstall[k] + 1;
                if (mdone[k]) mdone[k] = 0;
                else if (mbusy[k]) begin
                    mcnt[k] = mcnt[k] + 1;
                    if (done) begin
                        mbusy[k] = 0; mdone[k] = 1;
                    end else if (mcnt[k] == tlim[k]) begin
                        mbusy[k] = 0; mdone[k] = 1; mto[k] = 1;
                    end
                end else if (e_div) begin
                    mbusy[k] = 1; mcnt[k] = 0;
                end
            end
        end
    end

    logic [13:0] act0, act1;
    assign act0 = {bus0.F_en, bus0.F_D_en, bus0.F_D_flush, bus0.D_E_en, bus0.no_op, bus0.CTRL_Flush,
                   bus0.M_bubble, bus0.fwd_a, bus0.fwd_b, bus0.div_start, bus0.div_busy, bus0.div_timeout};
    assign act1 = {bus1.F_en, bus1.F_D_en, bus1.F_D_flush, bus1.D_E_en, bus1.no_op, bus1.CTRL_Flush,
                   bus1.M_bubble, bus1.fwd_a, bus1.fwd_b, bus1.div_start, bus1.div_busy, bus1.div_timeout};

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [21:0] e0, e1;
        e0 = {model_out(mbusy[0], mdone[0], mto[0]), SW'(mstall[0])};
        e1 = {model_out(mbusy[1], mdone[1], mto[1]), SW'(mstall[1])};
        n_chk = n_chk + 2;
        if ({act0, bus0.stall_cycles} !== e0) begin
            n_fail++;
            $display("FAIL model_dut0 t=%0t got %h expected %h", $time, {act0, bus0.stall_cycles}, e0);
        end
        if ({act1, bus1.stall_cycles} !== e1) begin
            n_fail++;
            $display("FAIL model_dut1 t=%0t got %h expected %h", $time, {act1, bus1.stall_cycles}, e1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        d_ra = 0; d_rb = 0; e_ra = 0; e_rb = 0; e_rd = 0; m_rd = 0; w_rd = 0;
        e_src = 0; e_we = 0; e_div = 0; e_redir = 0; m_we = 0; w_we = 0; done = 0;
    endtask

    initial begin
        logic [SW-1:0] s0;
        idle_in();
        rst = 1;
        // Reset state
        @(negedge clk);
        chk("rst_F_en", bus0.F_en, 0);
        chk("rst_busy", bus0.div_busy, 0);
        chk("rst_stall", bus0.stall_cycles, 0);
        chk("rst_timeout", bus0.div_timeout, 0);
        next(); next();
        rst = 0;
        @(negedge clk);
        chk("post_rst_F_en", bus0.F_en, 1);

        // Load-use on rb
        next();
        e_src = 2'b01; e_we = 1; e_rd = 5; d_rb = 5; d_ra = 1;
        @(negedge clk);
        chk("lu_no_op", bus0.no_op, 1);
        chk("lu_F_en", bus0.F_en, 0);
        chk("lu_F_D_en", bus0.F_D_en, 0);
        chk("lu_D_E_en", bus0.D_E_en, 1);
        next();
        idle_in();
        @(negedge clk);
        chk("lu_release", {bus0.F_en, bus0.no_op}, 2'b10);
        next();
        e_src = 2'b01; e_we = 1; e_rd = 0; d_rb = 0;
        @(negedge clk);
        chk("lu_x0_no_op", bus0.no_op, 0);
        chk("lu_x0_F_en", bus0.F_en, 1);

        // Redirect together with load-use
        next();
        e_src = 2'b01; e_we = 1; e_rd = 5; d_rb = 5; e_redir = 1;
        @(negedge clk);
        chk("rd_CTRL_Flush", bus0.CTRL_Flush, 1);
        chk("rd_F_D_flush", bus0.F_D_flush, 1);
        chk("rd_no_op", bus0.no_op, 0);
        chk("rd_F_en", bus0.F_en, 1);

        // Forwarding
        next();
        idle_in();
        m_rd = 3; w_rd = 3; e_ra = 3; e_rb = 3; m_we = 1; w_we = 1;
        @(negedge clk);
        chk("fwd_a_M", bus0.fwd_a, 2'b10);
        chk("fwd_b_M", bus0.fwd_b, 2'b10);
        next();
        m_we = 0;
        @(negedge clk);
        chk("fwd_a_W", bus0.fwd_a, 2'b01);
        next();
        m_we = 1; e_ra = 0;
        @(negedge clk);
        chk("fwd_a_x0", bus0.fwd_a, 2'b00);

        // Divide with done four cycles after the launch
        next();
        idle_in();
        e_div = 1;
        @(negedge clk);
        s0 = bus0.stall_cycles;
        chk("div_start_N", bus0.div_start, 1);
        chk("div_F_en_N", bus0.F_en, 0);
        chk("div_busy_N", bus0.div_busy, 0);
        chk("div_M_bubble_N", bus0.M_bubble, 1);
        for (int i = 1; i <= 4; i++) begin
            next();
            done = (i == 4);
            @(negedge clk);
            chk("div_start_busy", bus0.div_start, 0);
            chk("div_busy_busy", bus0.div_busy, 1);
            chk("div_F_en_busy", bus0.F_en, 0);
        end
        next();
        done = 0;
        @(negedge clk);
        chk("div_F_en_done", bus0.F_en, 1);
        chk("div_busy_done", bus0.div_busy, 0);
        chk("div_start_done", bus0.div_start, 0);
        chk("div_stall_delta", bus0.stall_cycles, 32'(s0 + 8'd5));
        chk("div_no_timeout", bus1.div_timeout, 0);
        next();
        e_div = 0;
        @(negedge clk);
        chk("div_after_F_en", bus0.F_en, 1);

        // Timeout on the short instance, divider never answers
        next();
        e_div = 1;
        @(negedge clk);
        chk("to_start", bus1.div_start, 1);
        for (int i = 1; i <= 4; i++) begin
            next();
            e_div = 0;
            @(negedge clk);
            chk("to_busy", bus1.div_busy, 1);
        end
        next();
        @(negedge clk);
        chk("to_done_busy", bus1.div_busy, 0);
        chk("to_flag", bus1.div_timeout, 1);
        chk("to_done_F_en", bus1.F_en, 1);
        repeat (15) next();
        @(negedge clk);
        chk("to_sticky1", bus1.div_timeout, 1);
        chk("to_sticky0", bus0.div_timeout, 1);

        // Stall counter saturation
        next();
        e_src = 2'b01; e_we = 1; e_rd = 7; d_ra = 7;
        repeat (300) next();
        @(negedge clk);
        chk("stall_sat", bus0.stall_cycles, SMAX);

        // Reset in the middle of a divide
        next();
        idle_in();
        e_div = 1;
        next();
        e_div = 0;
        next();
        rst = 1;
        @(negedge clk);
        chk("mrst_F_en", bus0.F_en, 0);
        chk("mrst_start", bus0.div_start, 0);
        next();
        @(negedge clk);
        chk("mrst_busy", bus0.div_busy, 0);
        chk("mrst_stall", bus0.stall_cycles, 0);
        chk("mrst_timeout", bus0.div_timeout, 0);
        next();
        rst = 0;
        @(negedge clk);
        chk("mrst_rel_F_en", bus0.F_en, 1);
        chk("mrst_rel_busy", bus0.div_busy, 0);
        chk("mrst_rel_start", bus0.div_start, 0);

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            next();
            rst = ($urandom_range(0, 63) == 0);
            d_ra = 5'($urandom_range(0, 7)); d_rb = 5'($urandom_range(0, 7));
            e_ra = 5'($urandom_range(0, 7)); e_rb = 5'($urandom_range(0, 7));
            e_rd = 5'($urandom_range(0, 7)); m_rd = 5'($urandom_range(0, 7));
            w_rd = 5'($urandom_range(0, 7));
            e_src = 2'($urandom_range(0, 3));
            e_we = 1'($urandom_range(0, 1)); m_we = 1'($urandom_range(0, 1));
            w_we = 1'($urandom_range(0, 1));
            e_div = ($urandom_range(0, 5) == 0);
            e_redir = ($urandom_range(0, 3) == 0);
            done = ($urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
